// File: rtl/imem_boot_loader_if.sv
// Byte-stream and instruction-memory write bus for imem_boot_loader.
//   byte_valid/byte_data : stream byte offered by the source
//   byte_ready           : loader accepts the byte on this cycle
//   mem_we/mem_addr/mem_wdata : one-cycle word write to instruction memory
// master: byte source / memory side. slave: the loader.
interface imem_boot_loader_if;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready;
  logic        mem_we;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;

  modport master (
    output byte_valid,
    output byte_data,
    input  byte_ready,
    input  mem_we,
    input  mem_addr,
    input  mem_wdata
  );

  modport slave (
    input  byte_valid,
    input  byte_data,
    output byte_ready,
    output mem_we,
    output mem_addr,
    output mem_wdata
  );
endinterface

// File: rtl/imem_boot_loader.sv
// Boot loader: receives a framed program image (16-bit word count, little-endian
// words, 8-bit data checksum), writes each word to instruction memory at byte
// addresses 0, 4, 8, ... and releases the core reset once the image verifies.
// Ports:
//   clk, rst  : clock, synchronous active-high reset
//   start     : begin a load (honoured in idle, done or error)
//   bus       : byte stream in, memory write port out (slave modport)
//   core_rst  : core reset, low only while a verified image is present
//   busy      : load in progress
//   done      : image loaded and checksum matched
//   error     : load aborted (oversize length or checksum mismatch)
module imem_boot_loader #(
  parameter int unsigned DEPTH = 1024
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  imem_boot_loader_if.slave   bus,
  output logic                core_rst,
  output logic                busy,
  output logic                done,
  output logic                error
);

  typedef enum logic [2:0] {
    StIdle,
    StLen,
    StData,
    StWrite,
    StCsum,
    StDone,
    StError
  } state_e;

  state_e      state_q, state_d;
  logic [1:0]  byte_cnt_q, byte_cnt_d;
  logic [15:0] len_q, len_d;
  logic [15:0] word_idx_q, word_idx_d;
  logic [7:0]  sum_q, sum_d;
  // Holds bytes 0..2 of the current word; byte 3 is merged straight into wdata.
  logic [23:0] shift_q, shift_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        ready;
  logic        accept;
  logic [15:0] len_full;

  assign ready  = (state_q == StLen) || (state_q == StData) || (state_q == StCsum);
  assign accept = bus.byte_valid && ready;

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    len_d      = len_q;
    word_idx_d = word_idx_q;
    sum_d      = sum_q;
    shift_d    = shift_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    len_full   = {bus.byte_data, len_q[7:0]};

    case (state_q)
      StIdle, StDone, StError: begin
        if (start) begin
          state_d    = StLen;
          byte_cnt_d = 2'd0;
          word_idx_d = 16'd0;
          sum_d      = 8'd0;
        end
      end
      StLen: begin
        if (accept) begin
          if (byte_cnt_q == 2'd0) begin
            len_d[7:0] = bus.byte_data;
            byte_cnt_d = 2'd1;
          end else begin
            len_d      = len_full;
            byte_cnt_d = 2'd0;
            if ({16'd0, len_full} > DEPTH) begin
              state_d = StError;
            end else if (len_full == 16'd0) begin
              state_d = StCsum;
            end else begin
              state_d = StData;
            end
          end
        end
      end
      StData: begin
        if (accept) begin
          shift_d    = {bus.byte_data, shift_q[23:8]};
          sum_d      = sum_q + bus.byte_data;
          byte_cnt_d = byte_cnt_q + 2'd1;
          if (byte_cnt_q == 2'd3) begin
            // Address and data are latched here so they are stable during WRITE
            // and keep their values afterwards.
            wdata_d = {bus.byte_data, shift_q};
            addr_d  = {14'd0, word_idx_q, 2'b00};
            state_d = StWrite;
          end
        end
      end
      StWrite: begin
        word_idx_d = word_idx_q + 16'd1;
        if (word_idx_q + 16'd1 == len_q) begin
          state_d = StCsum;
        end else begin
          state_d = StData;
        end
      end
      StCsum: begin
        if (accept) begin
          state_d = (bus.byte_data == sum_q) ? StDone : StError;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      byte_cnt_q <= 2'd0;
      len_q      <= 16'd0;
      word_idx_q <= 16'd0;
      sum_q      <= 8'd0;
      shift_q    <= 24'd0;
      addr_q     <= 32'd0;
      wdata_q    <= 32'd0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      len_q      <= len_d;
      word_idx_q <= word_idx_d;
      sum_q      <= sum_d;
      shift_q    <= shift_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
    end
  end

  assign bus.byte_ready = ready;
  assign bus.mem_we     = (state_q == StWrite);
  assign bus.mem_addr   = addr_q;
  assign bus.mem_wdata  = wdata_q;
  assign core_rst       = (state_q != StDone);
  assign busy           = (state_q == StLen) || (state_q == StData) ||
                          (state_q == StWrite) || (state_q == StCsum);
  assign done           = (state_q == StDone);
  assign error          = (state_q == StError);

endmodule
